// File: rtl/neuron_update_sequencer.sv
// Bus master that runs one integrate-and-fire timestep on a neuron adder unit:
// one saturating weight accumulation per active synapse, then leak/threshold.
module neuron_update_sequencer #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_SYN    = 2**(ADDR_WIDTH-1),
  parameter int THRESHOLD  = 1000,
  parameter int LEAK       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_SYN-1:0]    spike_in,
  output logic                  busy,
  output logic                  done,
  output logic                  spike_out,
  output logic [DATA_WIDTH-1:0] vm_out,
  output logic                  bus_read,
  output logic                  bus_write,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  localparam int IW = ADDR_WIDTH - 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SCAN  = 3'd1;
  localparam logic [2:0] S_WB    = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] VM_ADDR  = {1'b1, {IW{1'b0}}};
  localparam logic [DATA_WIDTH-1:0] THR_VAL  = DATA_WIDTH'(THRESHOLD);
  localparam logic [DATA_WIDTH-1:0] LEAK_VAL = DATA_WIDTH'(LEAK);

  logic [2:0]            state;
  logic [NUM_SYN-1:0]    pend;
  logic [DATA_WIDTH-1:0] vm_shadow;
  logic                  fire;

  logic [IW-1:0]         low_idx;
  logic [DATA_WIDTH-1:0] sat_sum;
  logic                  fire_now;
  logic [DATA_WIDTH-1:0] leak_val;

  // Lowest set bit wins: scan downward so the last hit is the smallest index.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    low_idx = '0;
    for (int j = NUM_SYN - 1; j >= 0; j--) begin
      if (pend[j]) low_idx = IW'(j);
    end
  end

  // A sum smaller than the old potential means the 16-bit add wrapped.
  assign sat_sum  = (bus_rdata < vm_shadow) ? '1 : bus_rdata;
  assign fire_now = (vm_shadow >= THR_VAL);
  assign leak_val = fire_now ? '0 :
                    (vm_shadow >= LEAK_VAL) ? (vm_shadow - LEAK_VAL) : '0;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    if (reset) begin
      state     <= S_IDLE;
      pend      <= '0;
      vm_shadow <= '0;
      fire      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          pend  <= spike_in;
          state <= S_SCAN;
        end
        S_SCAN: if (pend != '0) begin
          pend  <= pend & ~(NUM_SYN'(1) << low_idx);
          state <= S_WB;
        end else begin
          state <= S_CHECK;
        end
        S_WB: begin
          vm_shadow <= sat_sum;
          state     <= S_SCAN;
        end
        S_CHECK: begin
          vm_shadow <= leak_val;
          fire      <= fire_now;
          state     <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; WB forwards the adder's registered sum.
  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    spike_out = (state == S_DONE) && fire;
    vm_out    = vm_shadow;
    bus_read  = 1'b0;
    bus_write = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    case (state)
      S_SCAN: if (pend != '0) begin
        bus_read = 1'b1;
        bus_addr = {1'b0, low_idx};
      end
      S_WB: begin
        bus_write = 1'b1;
        bus_addr  = VM_ADDR;
        bus_wdata = sat_sum;
      end
      S_CHECK: begin
        bus_write = 1'b1;
        bus_addr  = VM_ADDR;
        bus_wdata = leak_val;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_neuron_update_sequencer.sv
// Directed bench for neuron_update_sequencer with a behavioural adder unit
// (registered rdata = vm + weight[addr], vm updated on writes to 0x20).
module tb_neuron_update_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] spike_in;
  logic        busy, done, spike_out;
  logic [15:0] vm_out;
  logic        bus_read, bus_write;
  logic [5:0]  bus_addr;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;

  int total = 0;
  int bad   = 0;

  neuron_update_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .spike_in(spike_in),
    .busy(busy), .done(done), .spike_out(spike_out), .vm_out(vm_out),
    .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // Adder unit model
  logic [15:0] w [0:31];
  logic [15:0] vm_model;
  always @(posedge clk) begin
    if (reset) begin
      vm_model  <= 16'd0;
      bus_rdata <= 16'd0;
    end else begin
      if (bus_read) bus_rdata <= vm_model + w[bus_addr[4:0]];
      if (bus_write && bus_addr == 6'h20) vm_model <= bus_wdata;
    end
  end

  // Observations of the most recent timestep
  int rd_q[$];
  int wr_q[$];
  int wa_q[$];
  int done_cyc, done_cnt, viol, busy_viol;
  logic spike_at_done;
  logic [15:0] vm_at_done;

  task automatic run_step(input logic [31:0] s, input int extra_start, input int budget);
    int cyc;
    rd_q.delete(); wr_q.delete(); wa_q.delete();
    done_cyc = -1; done_cnt = 0; viol = 0; busy_viol = 0;
    spike_at_done = 1'b0; vm_at_done = 16'hxxxx;
    @(negedge clk);
    spike_in = s;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    spike_in = ~s;
    cyc = 1;
    while (cyc <= budget) begin
      if (bus_read && bus_write) viol++;
      if (!bus_read && !bus_write && (bus_addr != 6'd0 || bus_wdata != 16'd0)) viol++;
      if (spike_out && !done) viol++;
      if (!busy) busy_viol++;
      if (bus_read) rd_q.push_back(int'(bus_addr));
      if (bus_write) begin
        wa_q.push_back(int'(bus_addr));
        wr_q.push_back(int'(bus_wdata));
      end
      if (done) begin
        done_cnt++;
        done_cyc      = cyc;
        spike_at_done = spike_out;
        vm_at_done    = vm_out;
        break;
      end
      start = (cyc == extra_start);
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; spike_in = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, spike_out, bus_read, bus_write} !== 5'b0 ||
        vm_out !== 16'd0 || bus_addr !== 6'd0 || bus_wdata !== 16'd0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b spk=%b rd=%b wr=%b vm=%0d addr=%0h wdata=%0h, want all 0",
               busy, done, spike_out, bus_read, bus_write, vm_out, bus_addr, bus_wdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int exp_rd[3] = '{0, 3, 31};
    int exp_wr[4] = '{100, 300, 350, 349};
    w[0] = 16'd100; w[3] = 16'd200; w[31] = 16'd50;
    run_step(32'h8000_0009, -1, 40);
    total++;
    if (rd_q.size() != 3) begin bad++; $display("FAIL basic_nreads: got %0d want 3", rd_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      total++;
      if (rd_q[i] != exp_rd[i]) begin bad++; $display("FAIL basic_read%0d: got %0h want %0h", i, rd_q[i], exp_rd[i]); end
    end
    total++;
    if (wr_q.size() != 4) begin bad++; $display("FAIL basic_nwrites: got %0d want 4", wr_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      total++;
      if (wr_q[i] != exp_wr[i] || wa_q[i] != 32'h20) begin
        bad++;
        $display("FAIL basic_write%0d: got %0d@%0h want %0d@20", i, wr_q[i], wa_q[i], exp_wr[i]);
      end
    end
    total++;
    if (done_cyc != 9) begin bad++; $display("FAIL basic_latency: got %0d want 9", done_cyc); end
    total++;
    if (spike_at_done !== 1'b0 || vm_at_done !== 16'd349) begin
      bad++; $display("FAIL basic_result: got spk=%b vm=%0d want spk=0 vm=349", spike_at_done, vm_at_done);
    end
    total++;
    if (viol != 0 || busy_viol != 0) begin
      bad++; $display("FAIL basic_bus_rules: got viol=%0d busy_viol=%0d want 0/0", viol, busy_viol);
    end
  endtask

  task automatic test_fire;
    // 349 + 152 = 501, leaked to 500
    w[1] = 16'd152;
    run_step(32'h2, -1, 20);
    total++;
    if (vm_at_done !== 16'd500 || spike_at_done !== 1'b0) begin
      bad++; $display("FAIL fire_prep: got vm=%0d spk=%b want vm=500 spk=0", vm_at_done, spike_at_done);
    end
    w[1] = 16'd600;
    run_step(32'h2, -1, 20);
    total++;
    if (wr_q.size() != 2 || wr_q[0] != 1100 || wr_q[1] != 0) begin
      bad++; $display("FAIL fire_writes: got n=%0d first=%0d want 1100,0", wr_q.size(),
                      (wr_q.size() > 0) ? wr_q[0] : -1);
    end
    total++;
    if (spike_at_done !== 1'b1 || vm_at_done !== 16'd0 || done_cyc != 5) begin
      bad++; $display("FAIL fire_result: got spk=%b vm=%0d lat=%0d want spk=1 vm=0 lat=5",
                      spike_at_done, vm_at_done, done_cyc);
    end
  endtask

  task automatic test_saturation;
    // 65000 + 1000 wraps to 464 -> clamps to 0xFFFF
    w[0] = 16'd65000; w[2] = 16'd1000;
    run_step(32'h5, -1, 30);
    total++;
    if (rd_q.size() != 2 || rd_q[0] != 0 || rd_q[1] != 2) begin
      bad++; $display("FAIL sat_reads: got n=%0d want 0,2", rd_q.size());
    end
    total++;
    if (wr_q.size() != 3 || wr_q[0] != 65000 || wr_q[1] != 65535 || wr_q[2] != 0) begin
      bad++; $display("FAIL sat_writes: got n=%0d mid=%0d want 65000,65535,0", wr_q.size(),
                      (wr_q.size() > 1) ? wr_q[1] : -1);
    end
    total++;
    if (spike_at_done !== 1'b1 || vm_at_done !== 16'd0 || done_cyc != 7) begin
      bad++; $display("FAIL sat_result: got spk=%b vm=%0d lat=%0d want 1/0/7", spike_at_done, vm_at_done, done_cyc);
    end
  endtask

  task automatic test_empty;
    run_step(32'h0, -1, 20);
    total++;
    if (rd_q.size() != 0 || wr_q.size() != 1 || wr_q[0] != 0 || wa_q[0] != 32'h20) begin
      bad++; $display("FAIL empty_bus: got reads=%0d writes=%0d want 0 reads, one write 0@20", rd_q.size(), wr_q.size());
    end
    total++;
    if (done_cyc != 3 || spike_at_done !== 1'b0 || vm_at_done !== 16'd0) begin
      bad++; $display("FAIL empty_result: got lat=%0d spk=%b vm=%0d want 3/0/0", done_cyc, spike_at_done, vm_at_done);
    end
  endtask

  task automatic test_busy_ignore;
    int extra;
    w[4] = 16'd10;
    run_step(32'h10, 2, 20);
    total++;
    if (done_cyc != 5 || done_cnt != 1 || vm_at_done !== 16'd9) begin
      bad++; $display("FAIL busy_start_latency: got lat=%0d n=%0d vm=%0d want 5/1/9", done_cyc, done_cnt, vm_at_done);
    end
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy || done || bus_read || bus_write) extra++;
    end
    total++;
    if (extra != 0) begin bad++; $display("FAIL busy_start_queued: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_back_to_back;
    // Second start lands in the IDLE cycle right after DONE.
    w[6] = 16'd20; w[7] = 16'd30;
    run_step(32'h40, -1, 20);
    total++;
    if (vm_at_done !== 16'd28 || done_cyc != 5) begin
      bad++; $display("FAIL b2b_first: got vm=%0d lat=%0d want 28/5", vm_at_done, done_cyc);
    end
    run_step(32'h80, -1, 20);
    total++;
    if (vm_at_done !== 16'd57 || done_cyc != 5 || rd_q.size() != 1 || rd_q[0] != 7) begin
      bad++; $display("FAIL b2b_second: got vm=%0d lat=%0d want 57/5 read 7", vm_at_done, done_cyc);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    w[0] = 16'd5; w[1] = 16'd5;
    @(negedge clk);
    spike_in = 32'h3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (busy || done || spike_out || bus_read || bus_write || bus_addr != 6'd0 || vm_out != 16'd0) begin
      bad++; $display("FAIL midreset_state: got busy=%b done=%b rd=%b wr=%b addr=%0h vm=%0d want all 0",
                      busy, done, bus_read, bus_write, bus_addr, vm_out);
    end
    reset = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL midreset_no_done: got %0d active cycles want 0", seen); end
    w[5] = 16'd7;
    run_step(32'h20, -1, 20);
    total++;
    if (vm_at_done !== 16'd6 || done_cyc != 5 || wr_q.size() != 2 || wr_q[0] != 7) begin
      bad++; $display("FAIL midreset_recover: got vm=%0d lat=%0d want 6/5", vm_at_done, done_cyc);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) w[i] = 16'd0;
    test_reset;
    test_basic;
    test_fire;
    test_saturation;
    test_empty;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
